muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_divstep.sv | 23 ++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit:
// FSM states, funct3 op encodings and per-op signedness helpers.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldivState_t;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   function automatic logic isDivOp(input logic [2:0] f3);
      return f3 inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic isRemOp(input logic [2:0] f3);
      return (f3 == OP_REM) || (f3 == OP_REMU);
   endfunction

   function automatic logic aIsSigned(input logic [2:0] f3);
      case (f3)
         OP_MULHU, OP_DIVU, OP_REMU: return 1'b0;
         default:                    return 1'b1;
      endcase
   endfunction

   function automatic logic bIsSigned(input logic [2:0] f3);
      case (f3)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage handshake between the pipeline (master) and the mul/div unit (slave).
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            kill;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] result;
   logic            done;
   logic            busy;
   logic            stall_idex;
   logic            stall_exmem;

   modport master (
      output start, kill, funct3, a, b,
      input  result, done, busy, stall_idex, stall_exmem
   );

   modport slave (
      input  start, kill, funct3, a, b,
      output result, done, busy, stall_idex, stall_exmem
   );
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module muldiv_divstep #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] remIn,
   input  logic            bitIn,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] remOut,
   output logic            qBit
);
   logic [XLEN-1:0] shiftedLow;
   logic            shiftedTop;

   // remIn < divisor, so a set top bit alone guarantees the divisor fits and
   // the XLEN-bit wrapped difference is the exact new remainder.
   always_comb begin
      shiftedTop = remIn[XLEN-1];
      shiftedLow = {remIn[XLEN-2:0], bitIn};
      qBit       = shiftedTop | (shiftedLow >= divisor);
      remOut     = qBit ? (shiftedLow - divisor) : shiftedLow;
   end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply retiring MUL_BPC bits
// per cycle, restoring divide one bit per cycle, sign fix-up on the way out.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_BPC = 1
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);
   localparam int              CNT_W     = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] MUL_STEPS = CNT_W'(XLEN / MUL_BPC);
   localparam logic [CNT_W-1:0] DIV_STEPS = CNT_W'(XLEN);
   localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   muldivState_t     stateReg;
   logic [CNT_W-1:0] cntReg;
   logic [2:0]       funct3Reg;
   logic             resSignReg;
   logic [XLEN-1:0]  accHiReg;
   logic [XLEN-1:0]  accLoReg;
   logic [XLEN-1:0]  opndReg;

   logic            aNeg, bNeg, divOp, divZero, divOvf, special, launchSign;
   logic [XLEN-1:0] aMag, bMag;

   always_comb begin
      aNeg       = aIsSigned(bus.funct3) & bus.a[XLEN-1];
      bNeg       = bIsSigned(bus.funct3) & bus.b[XLEN-1];
      aMag       = aNeg ? -bus.a : bus.a;
      bMag       = bNeg ? -bus.b : bus.b;
      divOp      = isDivOp(bus.funct3);
      divZero    = (bus.b == '0);
      divOvf     = aIsSigned(bus.funct3) && (bus.a == MOST_NEG) && (bus.b == '1);
      special    = divOp & (divZero | divOvf);
      launchSign = isRemOp(bus.funct3) ? aNeg : (aNeg ^ bNeg);
   end

   // Multiply: accHi accumulates, accLo holds the unconsumed multiplier bits and
   // fills from the top with finished low product bits as it shifts right.
   logic [XLEN+MUL_BPC-1:0] partial, mulSum;

   always_comb begin
      partial = {{MUL_BPC{1'b0}}, opndReg} * {{XLEN{1'b0}}, accLoReg[MUL_BPC-1:0]};
      mulSum  = {{MUL_BPC{1'b0}}, accHiReg} + partial;
   end

   // Divide: accHi is the partial remainder, accLo shifts the dividend out and
   // quotient bits in.
   logic [XLEN-1:0] remNext;
   logic            qBit;

   muldiv_divstep #(.XLEN(XLEN)) divStep (
      .remIn   (accHiReg),
      .bitIn   (accLoReg[XLEN-1]),
      .divisor (opndReg),
      .remOut  (remNext),
      .qBit    (qBit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg   <= IDLE;
         cntReg     <= '0;
         funct3Reg  <= '0;
         resSignReg <= 1'b0;
         accHiReg   <= '0;
         accLoReg   <= '0;
         opndReg    <= '0;
      end else if (bus.kill) begin
         stateReg <= IDLE;
      end else begin
         case (stateReg)
            IDLE: begin
               if (bus.start) begin
                  funct3Reg <= bus.funct3;
                  opndReg   <= divOp ? bMag : aMag;
                  if (special) begin
                     // Final quotient/remainder are loaded raw; no iteration needed.
                     stateReg   <= DONE;
                     cntReg     <= '0;
                     resSignReg <= 1'b0;
                     accHiReg   <= divZero ? bus.a : '0;
                     accLoReg   <= divZero ? '1 : bus.a;
                  end else begin
                     stateReg   <= CALC;
                     cntReg     <= divOp ? DIV_STEPS : MUL_STEPS;
                     resSignReg <= launchSign;
                     accHiReg   <= '0;
                     accLoReg   <= divOp ? aMag : bMag;
                  end
               end
            end
            CALC: begin
               cntReg <= cntReg - CNT_W'(1);
               if (isDivOp(funct3Reg)) begin
                  accHiReg <= remNext;
                  accLoReg <= {accLoReg[XLEN-2:0], qBit};
               end else begin
                  accHiReg <= mulSum[XLEN+MUL_BPC-1:MUL_BPC];
                  accLoReg <= {mulSum[MUL_BPC-1:0], accLoReg[XLEN-1:MUL_BPC]};
               end
               if (cntReg == CNT_W'(1)) begin
                  stateReg <= DONE;
               end
            end
            DONE:    stateReg <= IDLE;
            default: stateReg <= IDLE;
         endcase
      end
   end

   logic [2*XLEN-1:0] prodFix;
   logic [XLEN-1:0]   divSel, divFix, resVal;

   always_comb begin
      prodFix = resSignReg ? -{accHiReg, accLoReg} : {accHiReg, accLoReg};
      divSel  = isRemOp(funct3Reg) ? accHiReg : accLoReg;
      divFix  = resSignReg ? -divSel : divSel;
      if (isDivOp(funct3Reg)) begin
         resVal = divFix;
      end else if (funct3Reg == OP_MUL) begin
         resVal = prodFix[XLEN-1:0];
      end else begin
         resVal = prodFix[2*XLEN-1:XLEN];
      end
   end

   logic stall;
   assign stall = ~reset & (((stateReg == IDLE) & bus.start & ~bus.kill) | (stateReg == CALC));

   assign bus.result      = (stateReg == DONE) ? resVal : '0;
   assign bus.done        = (stateReg == DONE);
   assign bus.busy        = (stateReg == CALC) || (stateReg == DONE);
   assign bus.stall_idex  = stall;
   assign bus.stall_exmem = stall;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a bit-serial (BPC=1) and a 4-bit-per-cycle
// instance checked every cycle against a plain-arithmetic timing/result model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   muldiv_if #(.XLEN(32)) bus1 ();
   muldiv_if #(.XLEN(32)) bus4 ();

   muldiv_unit #(.XLEN(32), .MUL_BPC(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   muldiv_unit #(.XLEN(32), .MUL_BPC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

   int nVec = 0;
   int nErr = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state per instance: launch cycle, iteration count, expected result.
   bit          act[2];
   int          launchCyc[2];
   int          latCyc[2];
   int          killCyc[2];
   logic [31:0] expRes[2];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] refRes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      case (f3)
         OP_MUL:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0];  end
         OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
         OP_MULHU:  begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return $signed(a) / $signed(b);
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Number of iteration cycles between launch and the done cycle.
   function automatic int latOf(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int bpc);
      if (!isDivOp(f3)) return 32 / bpc;
      if (b == 0) return 0;
      if ((f3 == OP_DIV || f3 == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return 32;
   endfunction

   // {result, done, busy, stall_idex, stall_exmem}
   function automatic logic [35:0] snap(input int w);
      if (w == 0) return {bus1.result, bus1.done, bus1.busy, bus1.stall_idex, bus1.stall_exmem};
      return {bus4.result, bus4.done, bus4.busy, bus4.stall_idex, bus4.stall_exmem};
   endfunction

   task automatic drive(input int w, input logic st, input logic kl, input logic [2:0] f3,
                        input logic [31:0] av, input logic [31:0] bv);
      if (w == 0) begin
         bus1.start = st; bus1.kill = kl; bus1.funct3 = f3; bus1.a = av; bus1.b = bv;
      end else begin
         bus4.start = st; bus4.kill = kl; bus4.funct3 = f3; bus4.a = av; bus4.b = bv;
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [35:0] o;
      logic        eDone, eBusy, eStall;
      logic [31:0] eRes;
      int          off;
      for (int w = 0; w < 2; w++) begin
         o = snap(w);
         eDone = 1'b0; eBusy = 1'b0; eStall = 1'b0; eRes = '0;
         if (!reset && act[w] && !(killCyc[w] >= 0 && cyc > killCyc[w])) begin
            off    = cyc - launchCyc[w];
            eStall = (off <= latCyc[w]);
            eBusy  = (off >= 1) && (off <= latCyc[w] + 1);
            eDone  = (off == latCyc[w] + 1);
            if (eDone) eRes = expRes[w];
         end
         chk($sformatf("dut%0d result", w),      o[35:4], eRes);
         chk($sformatf("dut%0d done", w),        o[3],    eDone);
         chk($sformatf("dut%0d busy", w),        o[2],    eBusy);
         chk($sformatf("dut%0d stall_idex", w),  o[1],    eStall);
         chk($sformatf("dut%0d stall_exmem", w), o[0],    eStall);
      end
   end

   // Called at posedge+1; returns at posedge+1 with start still asserted so a
   // following call launches back-to-back.
   task automatic doOp(input int w, input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] lit, input int litStall, input int abortAt, input bit abortRst);
      int          stallCnt;
      bit          sawDone;
      logic [31:0] got;
      logic [35:0] o;
      stallCnt = 0; sawDone = 0; got = '0;
      drive(w, 1'b1, 1'b0, f3, av, bv);
      act[w] = 1'b1; launchCyc[w] = cyc; killCyc[w] = -1;
      latCyc[w] = latOf(f3, av, bv, (w == 0) ? 1 : 4);
      expRes[w] = refRes(f3, av, bv);
      for (int k = 0; k <= latCyc[w] + 1; k++) begin
         if (k == abortAt && !abortRst) begin
            drive(w, 1'b1, 1'b1, f3, av, bv);
            killCyc[w] = cyc;
         end
         #1;
         o = snap(w);
         if (o[1]) stallCnt++;
         if (o[3]) begin sawDone = 1'b1; got = o[35:4]; end
         if (k == abortAt) break;
         @(posedge clk); #1;
      end
      if (abortAt < 0) begin
         chk($sformatf("dut%0d f3=%0d done seen", w, f3), sawDone, 1'b1);
         chk($sformatf("dut%0d f3=%0d %h,%h literal", w, f3, av, bv), got, lit);
         $display("op dut%0d f3=%0d a=%h b=%h -> %h (stall %0d)", w, f3, av, bv, got, stallCnt);
      end else if (abortRst) begin
         chk("no done before reset", sawDone, 1'b0);
         reset = 1'b1; act[0] = 1'b0; act[1] = 1'b0;
         #1;
         chk("dut0 outputs under reset", snap(0), 36'h0);
         chk("dut1 outputs under reset", snap(1), 36'h0);
         $display("reset mid-op dut%0d at offset %0d", w, abortAt);
         @(posedge clk); #1;
         @(posedge clk); #1;
         reset = 1'b0;
         drive(w, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         @(posedge clk); #1;
      end else begin
         chk("no done before kill", sawDone, 1'b0);
         @(posedge clk); #1;
         drive(w, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         #1;
         chk("outputs after kill", snap(w), 36'h0);
         $display("kill dut%0d at offset %0d", w, abortAt);
         @(posedge clk); #1;
      end
      if (litStall >= 0) chk($sformatf("dut%0d f3=%0d stall cycles", w, f3), stallCnt, litStall);
   endtask

   task automatic goIdle();
      drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [35:0] o;
      act[0] = 1'b0; act[1] = 1'b0; killCyc[0] = -1; killCyc[1] = -1;
      drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("dut0 reset state", snap(0), 36'h0);
      chk("dut1 reset state", snap(1), 36'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Back-to-back chain on the bit-serial instance.
      doOp(0, OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, -1, 0);
      doOp(0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, -1, 0);
      doOp(0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, -1, 0);
      doOp(0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1, 0);
      doOp(0, OP_MULH,   32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 33, -1, 0);
      doOp(0, OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, -1, 0);
      doOp(0, OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, -1, 0);
      doOp(0, OP_DIVU,   32'd100,       32'd7,         32'd14,        33, -1, 0);
      doOp(0, OP_REMU,   32'd100,       32'd7,         32'd2,         33, -1, 0);
      doOp(0, OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  -1, 0);
      doOp(0, OP_REM,    32'd5,         32'd0,         32'd5,         1,  -1, 0);
      doOp(0, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  -1, 0);
      doOp(0, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  -1, 0);
      doOp(0, OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  -1, 0);
      doOp(0, OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33, -1, 0);
      doOp(0, OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, -1, 0);
      doOp(0, OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, -1, 0);
      doOp(0, OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33, -1, 0);
      goIdle();

      // Kill in the 10th CALC cycle, then a fresh op.
      doOp(0, OP_MUL, 32'd5, 32'd6, 32'h0, 11, 10, 0);
      doOp(0, OP_MUL, 32'd3, 32'd4, 32'd12, 33, -1, 0);
      goIdle();

      // start together with kill must not launch.
      drive(0, 1'b1, 1'b1, OP_MUL, 32'd3, 32'd4);
      #1;
      o = snap(0);
      chk("start+kill stall", o[1:0], 2'b00);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      o = snap(0);
      chk("start+kill busy", o[2], 1'b0);
      $display("start with kill in IDLE ignored");
      @(posedge clk); #1;

      // Reset in the middle of a divide, then a fresh op.
      doOp(0, OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'h0,  -1, 5, 1);
      doOp(0, OP_DIVU, 32'd100,       32'd7, 32'd14, 33, -1, 0);
      goIdle();

      // Four multiplier bits per cycle.
      doOp(1, OP_MUL,    32'h1234,      32'h10,        32'h0001_2340, 9,  -1, 0);
      doOp(1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9,  -1, 0);
      doOp(1, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9,  -1, 0);
      doOp(1, OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 9,  -1, 0);
      doOp(1, OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, -1, 0);
      goIdle();

      repeat (2) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule
